dekatron_step_scheduler: RTL



---
 rtl/dekatron_step_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dekatron_step_scheduler.sv
// Round-robin scheduler sharing one dekatron guide-pulse generator among REQ_NUM requesters.
// Each step drives a two-phase Guide1/Guide2 sequence, then a settle gap ending in a one-cycle Ack.
module dekatron_step_scheduler #(
    parameter int unsigned REQ_NUM      = 3,
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic               hsClk,
    input  logic               Rst,
    input  logic [REQ_NUM-1:0] Req,
    input  logic [REQ_NUM-1:0] Dec,
    input  logic               Hold,
    output logic [REQ_NUM-1:0] Ack,
    output logic [REQ_NUM-1:0] Sel,
    output logic               Guide1,
    output logic               Guide2,
    output logic               Busy
);

    localparam int unsigned MaxCyc = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned IdxW   = $clog2(REQ_NUM);

    localparam logic [CntW-1:0] PhaseLoad = CntW'(PHASE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad   = CntW'(GAP_CYCLES - 1);
    localparam logic [IdxW-1:0] PtrInit   = IdxW'(REQ_NUM - 1);

    typedef enum logic [1:0] {StIdle, StPh1, StPh2, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic              dec_q, dec_d;

    logic [REQ_NUM-1:0] ack_q, ack_d;
    logic [REQ_NUM-1:0] sel_q, sel_d;
    logic               guide1_q, guide1_d;
    logic               guide2_q, guide2_d;
    logic               busy_q, busy_d;

    logic               grant_found;
    logic [IdxW-1:0]    grant_idx;
    logic [IdxW-1:0]    scan_idx;

    // State register
    always_ff @(posedge hsClk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= PtrInit;
            gnt_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dec_q   <= dec_d;
        end
    end

    // Round-robin search starts just after the last granted channel
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= REQ_NUM; i++) begin
            scan_idx = IdxW'((32'(ptr_q) + i) % REQ_NUM);
            if (!grant_found && Req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        dec_d   = dec_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found && !Hold) begin
                    state_d = StPh1;
                    cnt_d   = PhaseLoad;
                    ptr_d   = grant_idx;
                    gnt_d   = grant_idx;
                    dec_d   = Dec[grant_idx];
                end
            end
            StPh1: begin
                if (cnt_q == '0) begin
                    state_d = StPh2;
                    cnt_d   = PhaseLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPh2: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state
    always_comb begin
        ack_d    = '0;
        sel_d    = '0;
        guide1_d = 1'b0;
        guide2_d = 1'b0;
        busy_d   = (state_d != StIdle);
        unique case (state_d)
            StPh1: begin
                sel_d[gnt_d] = 1'b1;
                guide1_d     = !dec_d;
                guide2_d     = dec_d;
            end
            StPh2: begin
                sel_d[gnt_d] = 1'b1;
                guide1_d     = dec_d;
                guide2_d     = !dec_d;
            end
            StGap: begin
                if (cnt_d == '0) begin
                    ack_d[gnt_d] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hsClk) begin
        if (Rst) begin
            ack_q    <= '0;
            sel_q    <= '0;
            guide1_q <= 1'b0;
            guide2_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            sel_q    <= sel_d;
            guide1_q <= guide1_d;
            guide2_q <= guide2_d;
            busy_q   <= busy_d;
        end
    end

    assign Ack    = ack_q;
    assign Sel    = sel_q;
    assign Guide1 = guide1_q;
    assign Guide2 = guide2_q;
    assign Busy   = busy_q;

endmodule
